axi_tdd_frame_sequencer: RTL and testbench
==========================================

# axi_tdd_frame_sequencer

Central timing controller for the TDD engine: on enable it arms, waits for a frame sync, applies a startup delay, then runs a free-running frame counter for a programmed number of frames. Its `tdd_counter`, `tdd_cstate` and `tdd_endof_frame` outputs are the shared timebase that every TDD channel compares against to generate its output. It sits between the AXI register map (asynchronous configuration values) and the array of TDD channel instances.

## Interface
- `REGISTER_WIDTH`, 32, width of counter, frame length, startup delay and burst count.
- `clk` in 1: single clock for the block.
- `resetn` in 1: synchronous, active-low reset.
- `tdd_enable` in 1: global run enable, level.
- `tdd_sync` in 1: external frame sync, single-cycle pulse, already synchronous to `clk`.
- `tdd_sync_soft` in 1: software sync pulse, OR'd with `tdd_sync`.
- `tdd_sync_rst` in 1: resync permission; used only when `AXI_TDD_SYNC_RESET_EN` is defined.
- `asy_frame_length` in REGISTER_WIDTH: last counter value of a frame; period is `frame_length+1` cycles.
- `asy_startup_delay` in REGISTER_WIDTH: cycles in WAITING between sync and the first frame.
- `asy_burst_count` in REGISTER_WIDTH: number of frames per run; 0 means infinite.
- `tdd_counter` out REGISTER_WIDTH: frame/delay counter.
- `tdd_cstate` out `axi_tdd_pkg::state_t`: current state.
- `tdd_endof_frame` out 1: one-cycle end-of-frame strobe.
- `tdd_burst_done` out 1: sticky flag, burst completed.

## Operation
- States (`axi_tdd_pkg::state_t`): IDLE=2'b00, ARMED=2'b01, WAITING=2'b10, RUNNING=2'b11.
- Shadow registers: `asy_*` values are loaded into internal copies every cycle while in IDLE and frozen in all other states. All comparisons use the shadow copies.
- IDLE: counter=0. Moves to ARMED when `tdd_enable=1` and `tdd_burst_done=0`.
- ARMED: counter=0. A sync (`tdd_sync|tdd_sync_soft`) moves to WAITING when the delay is nonzero, otherwise directly to RUNNING. The counter stays 0.
- WAITING: counter increments each cycle. When `counter==startup_delay-1`: move to RUNNING and set counter to 0. A startup delay of N gives exactly N cycles in WAITING.
- RUNNING: counter increments each cycle. At `counter==frame_length`:
  - `tdd_endof_frame` asserts in that same cycle.
  - The counter wraps to 0 and the frame count increments.
  - If `burst_count!=0` and the completed frame count equals `burst_count`: go to IDLE and set `tdd_burst_done`.
- `frame_length==0`: each frame lasts one cycle and `tdd_endof_frame` stays high for every RUNNING cycle.
- `tdd_enable` low in any state: next state is IDLE, counter and frame count clear to 0, and no end-of-frame strobe is produced (abort).
- `tdd_burst_done` clears when `tdd_enable=0`. While it is set, IDLE does not re-arm even if `tdd_enable=1`.
- Sync in IDLE, WAITING or RUNNING is ignored, except as described under Configuration.
- Counter arithmetic is modulo 2^REGISTER_WIDTH. It never overflows in practice because the compare bound is always reached first.

## Timing
- Reset values: `tdd_cstate=IDLE`, `tdd_counter=0`, `tdd_endof_frame=0`, `tdd_burst_done=0`, all shadow registers and the frame count 0.
- All outputs are registered. `tdd_endof_frame` is asserted in the same cycle that `tdd_counter==frame_length` and `tdd_cstate==RUNNING`.
- `tdd_enable` rising to ARMED: 1 cycle.
- Sync pulse at cycle k: state changes at k+1 and the counter holds 0 at k+1.
- RUNNING with counter 0 first appears `startup_delay+1` cycles after the sync cycle (1 cycle when the delay is 0).
- Sync and `tdd_enable` falling in the same cycle: IDLE wins.
- Reset mid-frame: everything returns to reset values on the next edge.

## Configuration
- Macro: `AXI_TDD_SYNC_RESET_EN`.
- Defined: in RUNNING or WAITING, a sync with `tdd_sync_rst=1` restarts the sequence.
  - Next state is WAITING if the delay is nonzero, otherwise RUNNING.
  - The counter and frame count clear to 0 and no end-of-frame strobe is produced.
  - A sync coinciding with `counter==frame_length` still produces the strobe in that cycle; the restart takes priority for the next state.
- Not defined: `tdd_sync_rst` is ignored, and syncs outside ARMED have no effect.

## Test plan
- Basic run: reset; `frame_length=9`, `startup_delay=0`, `burst=0`, enable, sync at t0 -> RUNNING at t0+1. Counter repeats 0..9 and `tdd_endof_frame` is high once every 10 cycles at counter 9.
- Startup delay: `startup_delay=5`, sync at t0 -> WAITING at t0+1..t0+5 with counter 0..4, then RUNNING with counter 0 at t0+6.
- Burst: `burst=3`, `frame_length=3` -> exactly 3 strobes, then IDLE with `tdd_burst_done=1`. No re-arm until enable toggles 0→1.
- Abort and shadowing: drop enable at counter 4 of `frame_length=9` -> IDLE next cycle, counter 0, no strobe. Changing `asy_frame_length` mid-run has no effect until the next IDLE.
- Edge case: `frame_length=0` -> strobe on every RUNNING cycle and counter constant 0. A sync while RUNNING without the macro is ignored.
- With `AXI_TDD_SYNC_RESET_EN`: sync with `tdd_sync_rst=1` at counter 6 -> counter 0 next cycle, no strobe, frame count reset (a burst of 2 then needs 2 further full frames).

Source files
------------

// File: rtl/axi_tdd_frame_sequencer.sv
// Purpose: TDD timebase sequencer. It arms on enable, waits for a sync, runs the startup delay,
//          then counts frames for a programmed burst. Optional macro: AXI_TDD_SYNC_RESET_EN.
// Latency: all outputs are registered; the state changes one cycle after a sync or enable edge.
// Backpressure: none; the timebase free-runs and cannot be stalled.

package axi_tdd_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    WAITING = 2'b10,
    RUNNING = 2'b11
  } state_t;
endpackage

module axi_tdd_frame_sequencer
  import axi_tdd_pkg::*;
#(
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      tdd_enable,
  input  logic                      tdd_sync,
  input  logic                      tdd_sync_soft,
  input  logic                      tdd_sync_rst,
  input  logic [REGISTER_WIDTH-1:0] asy_frame_length,
  input  logic [REGISTER_WIDTH-1:0] asy_startup_delay,
  input  logic [REGISTER_WIDTH-1:0] asy_burst_count,
  output logic [REGISTER_WIDTH-1:0] tdd_counter,
  output state_t                    tdd_cstate,
  output logic                      tdd_endof_frame,
  output logic                      tdd_burst_done
);

  localparam int W = REGISTER_WIDTH;

  // Shadow copies of the configuration. They track the register map only in IDLE so that
  // a run always sees one consistent set of values.
  logic [W-1:0] frame_length;
  logic [W-1:0] startup_delay;
  logic [W-1:0] burst_count;
  logic [W-1:0] frame_cnt;

  state_t       state_nxt;
  logic [W-1:0] counter_nxt;
  logic [W-1:0] frame_cnt_nxt;
  logic         burst_done_nxt;
  logic         endof_frame_nxt;
  logic         sync;
  logic         restart;

  assign sync = tdd_sync | tdd_sync_soft;

`ifdef AXI_TDD_SYNC_RESET_EN
  // A permitted sync during a delay or a run restarts the sequence from its beginning.
  assign restart = sync & tdd_sync_rst & ((tdd_cstate == WAITING) || (tdd_cstate == RUNNING));
`else
  logic unused_sync_rst;
  assign unused_sync_rst = tdd_sync_rst;
  assign restart         = 1'b0;
`endif

  // Shadow configuration capture: follows the register map only while idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_length  <= '0;
      startup_delay <= '0;
      burst_count   <= '0;
    end else if (tdd_cstate == IDLE) begin
      frame_length  <= asy_frame_length;
      startup_delay <= asy_startup_delay;
      burst_count   <= asy_burst_count;
    end
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tdd_cstate      <= IDLE;
      tdd_counter     <= '0;
      frame_cnt       <= '0;
      tdd_burst_done  <= 1'b0;
      tdd_endof_frame <= 1'b0;
    end else begin
      tdd_cstate      <= state_nxt;
      tdd_counter     <= counter_nxt;
      frame_cnt       <= frame_cnt_nxt;
      tdd_burst_done  <= burst_done_nxt;
      tdd_endof_frame <= endof_frame_nxt;
    end
  end

  // Next-state logic. Dropping enable aborts from any state and takes priority over everything.
  always_comb begin
    state_nxt      = tdd_cstate;
    counter_nxt    = tdd_counter;
    frame_cnt_nxt  = frame_cnt;
    burst_done_nxt = tdd_burst_done;
    if (!tdd_enable) begin
      state_nxt      = IDLE;
      counter_nxt    = '0;
      frame_cnt_nxt  = '0;
      burst_done_nxt = 1'b0;
    end else if (restart) begin
      state_nxt     = (startup_delay != '0) ? WAITING : RUNNING;
      counter_nxt   = '0;
      frame_cnt_nxt = '0;
    end else begin
      case (tdd_cstate)
        IDLE: begin
          counter_nxt   = '0;
          frame_cnt_nxt = '0;
          // A completed burst keeps the block parked until enable is cycled.
          if (!tdd_burst_done) state_nxt = ARMED;
        end
        ARMED: begin
          counter_nxt   = '0;
          frame_cnt_nxt = '0;
          if (sync) state_nxt = (startup_delay != '0) ? WAITING : RUNNING;
        end
        WAITING: begin
          // WAITING is only entered with a nonzero delay, so delay-1 cannot underflow here.
          if (tdd_counter == startup_delay - 1'b1) begin
            state_nxt   = RUNNING;
            counter_nxt = '0;
          end else begin
            counter_nxt = tdd_counter + 1'b1;
          end
        end
        RUNNING: begin
          if (tdd_counter == frame_length) begin
            counter_nxt   = '0;
            frame_cnt_nxt = frame_cnt + 1'b1;
            if ((burst_count != '0) && (frame_cnt + 1'b1 == burst_count)) begin
              state_nxt      = IDLE;
              frame_cnt_nxt  = '0;
              burst_done_nxt = 1'b1;
            end
          end else begin
            counter_nxt = tdd_counter + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: the strobe is registered so it lines up with the last count of each frame.
  // The shadow length is safe to use here because RUNNING is never entered straight from IDLE.
  always_comb begin
    endof_frame_nxt = (state_nxt == RUNNING) && (counter_nxt == frame_length);
  end

endmodule

// File: tb/tb_axi_tdd_frame_sequencer.sv
module tb_axi_tdd_frame_sequencer;
  import axi_tdd_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         tdd_enable = 1'b0;
  logic         tdd_sync = 1'b0;
  logic         tdd_sync_soft = 1'b0;
  logic         tdd_sync_rst = 1'b0;
  logic [W-1:0] asy_frame_length = '0;
  logic [W-1:0] asy_startup_delay = '0;
  logic [W-1:0] asy_burst_count = '0;
  logic [W-1:0] tdd_counter;
  state_t       tdd_cstate;
  logic         tdd_endof_frame;
  logic         tdd_burst_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_tdd_frame_sequencer #(.REGISTER_WIDTH(W)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .tdd_enable       (tdd_enable),
    .tdd_sync         (tdd_sync),
    .tdd_sync_soft    (tdd_sync_soft),
    .tdd_sync_rst     (tdd_sync_rst),
    .asy_frame_length (asy_frame_length),
    .asy_startup_delay(asy_startup_delay),
    .asy_burst_count  (asy_burst_count),
    .tdd_counter      (tdd_counter),
    .tdd_cstate       (tdd_cstate),
    .tdd_endof_frame  (tdd_endof_frame),
    .tdd_burst_done   (tdd_burst_done)
  );

  // Advance one clock; outputs are sampled 1ns after the edge, inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [W-1:0] cnt,
                           input logic eof, input logic done);
    check({tag, " state"}, W'(tdd_cstate), W'(st));
    check({tag, " counter"}, tdd_counter, cnt);
    check({tag, " eof"}, W'(tdd_endof_frame), W'(eof));
    check({tag, " done"}, W'(tdd_burst_done), W'(done));
  endtask

  // Timeline model: j cycles after the sync edge, with delay D, last count L and burst B.
  // The first D cycles are the delay, then frames of L+1 cycles follow until B are complete.
  function automatic void model(input int j, input int d, input int l, input int b,
                                output logic [1:0] st, output logic [W-1:0] cnt,
                                output logic eof, output logic done);
    int r;
    int frame;
    if (j <= d) begin
      st = 2'b10; cnt = W'(j - 1); eof = 1'b0; done = 1'b0;
    end else begin
      r     = j - d - 1;
      frame = r / (l + 1);
      if (b != 0 && frame >= b) begin
        st = 2'b00; cnt = '0; eof = 1'b0; done = 1'b1;
      end else begin
        st = 2'b11; cnt = W'(r % (l + 1)); eof = ((r % (l + 1)) == l); done = 1'b0;
      end
    end
  endfunction

  task automatic arm(input int d, input int l, input int b);
    tdd_enable = 1'b0;
    step();
    asy_startup_delay = W'(d);
    asy_frame_length  = W'(l);
    asy_burst_count   = W'(b);
    tdd_enable        = 1'b1;
    step();
    check_all("arm", 2'b01, '0, 1'b0, 1'b0);
  endtask

  // Arm, sync, then follow n cycles against the model while scrambling the live config
  // and throwing stray (non-restart) syncs at the block.
  task automatic run_seq(input int d, input int l, input int b, input int n);
    logic [1:0]   st;
    logic [W-1:0] cnt;
    logic         eof;
    logic         done;
    arm(d, l, b);
    repeat ($urandom_range(0, 2)) begin
      step();
      check_all("armed_hold", 2'b01, '0, 1'b0, 1'b0);
    end
    if ($urandom_range(0, 1) == 1) tdd_sync = 1'b1;
    else tdd_sync_soft = 1'b1;
    step();
    for (int j = 1; j <= n; j++) begin
      model(j, d, l, b, st, cnt, eof, done);
      check_all($sformatf("seq d=%0d l=%0d b=%0d j=%0d", d, l, b, j), st, cnt, eof, done);
      asy_frame_length  = $urandom;
      asy_startup_delay = $urandom;
      asy_burst_count   = $urandom;
      tdd_sync          = ($urandom_range(0, 3) == 0);
      tdd_sync_soft     = 1'b0;
      tdd_sync_rst      = 1'b0;
      step();
    end
    tdd_sync = 1'b0;
  endtask

  initial begin
    int d, l, b;
    logic [1:0]   st;
    logic [W-1:0] cnt;
    logic         eof;
    logic         done;

    // Reset values
    resetn = 1'b0;
    step();
    step();
    check_all("reset", 2'b00, '0, 1'b0, 1'b0);
    resetn = 1'b1;
    step();
    check_all("idle_no_enable", 2'b00, '0, 1'b0, 1'b0);

    // Basic run, startup delay, burst and single-cycle frames
    run_seq(0, 9, 0, 32);
    run_seq(5, 9, 0, 20);
    run_seq(0, 3, 3, 16);

    // Burst done holds off re-arm until enable is cycled
    repeat (3) begin
      step();
      check_all("no_rearm", 2'b00, '0, 1'b0, 1'b1);
    end
    tdd_enable = 1'b0;
    step();
    check_all("done_clear", 2'b00, '0, 1'b0, 1'b0);
    tdd_enable = 1'b1;
    step();
    check_all("rearm", 2'b01, '0, 1'b0, 1'b0);

    run_seq(0, 0, 0, 8);
    run_seq(3, 0, 4, 10);

    // Abort at counter 4 of a 10-cycle frame
    arm(0, 9, 0);
    tdd_sync = 1'b1;
    step();
    tdd_sync = 1'b0;
    repeat (4) step();
    check_all("pre_abort", 2'b11, W'(4), 1'b0, 1'b0);
    tdd_enable = 1'b0;
    step();
    check_all("abort", 2'b00, '0, 1'b0, 1'b0);

    // Sync and enable falling together: IDLE wins
    arm(2, 5, 0);
    tdd_sync   = 1'b1;
    tdd_enable = 1'b0;
    step();
    tdd_sync = 1'b0;
    check_all("sync_vs_disable", 2'b00, '0, 1'b0, 1'b0);

    // Reset mid-frame
    arm(1, 7, 0);
    tdd_sync_soft = 1'b1;
    step();
    tdd_sync_soft = 1'b0;
    repeat (4) step();
    resetn = 1'b0;
    step();
    check_all("reset_mid", 2'b00, '0, 1'b0, 1'b0);
    resetn = 1'b1;

`ifdef AXI_TDD_SYNC_RESET_EN
    // Restart at counter 6: the two-frame burst starts over from the restart edge
    arm(0, 9, 2);
    tdd_sync = 1'b1;
    step();
    tdd_sync = 1'b0;
    repeat (6) step();
    check_all("pre_restart", 2'b11, W'(6), 1'b0, 1'b0);
    tdd_sync     = 1'b1;
    tdd_sync_rst = 1'b1;
    step();
    tdd_sync     = 1'b0;
    tdd_sync_rst = 1'b0;
    for (int j = 1; j <= 22; j++) begin
      model(j, 0, 9, 2, st, cnt, eof, done);
      check_all($sformatf("restart j=%0d", j), st, cnt, eof, done);
      step();
    end
`else
    // A sync with resync permission mid-run is ignored in this build
    arm(0, 9, 0);
    tdd_sync = 1'b1;
    step();
    tdd_sync = 1'b0;
    repeat (6) step();
    tdd_sync     = 1'b1;
    tdd_sync_rst = 1'b1;
    step();
    tdd_sync     = 1'b0;
    tdd_sync_rst = 1'b0;
    check_all("sync_ignored", 2'b11, W'(7), 1'b0, 1'b0);
`endif

    // Randomized scenarios
    for (int s = 0; s < 12; s++) begin
      d = $urandom_range(0, 6);
      l = $urandom_range(0, 7);
      b = $urandom_range(0, 3);
      run_seq(d, l, b, d + ((b == 0) ? 2 : b) * (l + 1) + 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
